// File: rtl/mem_req_initiator.sv
// mem_req_initiator
//   Core-side load/store initiator for the shared data memory. Accepts one
//   pipeline load/store at a time and checks its alignment. It turns the
//   request into an aligned 64-bit single-beat access with byte enables. The
//   request is held until mem_ready, and the shifted, extended load data is
//   returned. A misaligned request or a memory timeout returns an error
//   response. All outputs are registered.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      pipeline request handshake (ready only in IDLE)
//   req_write, req_size      store flag, size (0=byte,1=half,2=word,3=dword)
//   req_signed               sign-extend load result
//   req_addr, req_wdata      byte address, right-justified store data
//   resp_valid               one-cycle response pulse
//   resp_rdata, resp_error   load result / error flag, valid with resp_valid
//   mem_valid, mem_ready     one-cycle request strobe / completion pulse
//   mem_address              aligned dword address
//   mem_write_data           store data shifted into its byte lanes
//   mem_byte_enable          lane enables
//   mem_write_enable         store flag
//   mem_read_data            read data, valid with mem_ready
//   mem_burst_mode/len       tied 0 (single-beat only)

module mem_req_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_error,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [63:0] mem_address,
    output logic [63:0] mem_write_data,
    output logic [7:0]  mem_byte_enable,
    output logic        mem_write_enable,
    input  logic [63:0] mem_read_data,
    output logic        mem_burst_mode,
    output logic [3:0]  mem_burst_len
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [1:0]    lat_size, lat_size_d;
    logic          lat_signed, lat_signed_d;
    logic [2:0]    lat_off, lat_off_d;

    logic          req_ready_d, resp_valid_d, resp_error_d, mem_valid_d, mem_write_enable_d;
    logic [63:0]   resp_rdata_d, mem_address_d, mem_write_data_d;
    logic [7:0]    mem_byte_enable_d;

    logic          misaligned;
    logic [7:0]    size_mask;

    assign mem_burst_mode = 1'b0;
    assign mem_burst_len  = 4'd0;

    function automatic logic [63:0] extend_load(input logic [63:0] raw, input logic [2:0] off,
                                                input logic [1:0] size, input logic sgn);
        logic [63:0] s;
        logic [63:0] r;
        s = raw >> {off, 3'b000};
        case (size)
            2'd0:    r = {{56{sgn & s[7]}},  s[7:0]};
            2'd1:    r = {{48{sgn & s[15]}}, s[15:0]};
            2'd2:    r = {{32{sgn & s[31]}}, s[31:0]};
            default: r = s;
        endcase
        return r;
    endfunction

    always_comb begin
        misaligned = 1'b0;
        size_mask  = 8'h01;
        case (req_size)
            2'd0:    begin misaligned = 1'b0;            size_mask = 8'h01; end
            2'd1:    begin misaligned = req_addr[0];     size_mask = 8'h03; end
            2'd2:    begin misaligned = |req_addr[1:0];  size_mask = 8'h0F; end
            default: begin misaligned = |req_addr[2:0];  size_mask = 8'hFF; end
        endcase
    end

    always_comb begin
        state_d            = state;
        cnt_d              = cnt;
        lat_size_d         = lat_size;
        lat_signed_d       = lat_signed;
        lat_off_d          = lat_off;
        req_ready_d        = req_ready;
        resp_valid_d       = 1'b0;
        resp_error_d       = 1'b0;
        resp_rdata_d       = '0;
        mem_valid_d        = 1'b0;
        mem_address_d      = mem_address;
        mem_write_data_d   = mem_write_data;
        mem_byte_enable_d  = mem_byte_enable;
        mem_write_enable_d = mem_write_enable;

        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    req_ready_d = 1'b0;
                    if (misaligned) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                    end else begin
                        state_d            = S_REQ;
                        mem_valid_d        = 1'b1;
                        mem_address_d      = {req_addr[63:3], 3'b000};
                        mem_write_data_d   = req_wdata << {req_addr[2:0], 3'b000};
                        mem_byte_enable_d  = size_mask << req_addr[2:0];
                        mem_write_enable_d = req_write;
                        lat_size_d         = req_size;
                        lat_signed_d       = req_signed;
                        lat_off_d          = req_addr[2:0];
                    end
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (mem_ready) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = mem_write_enable ? 64'd0
                                 : extend_load(mem_read_data, lat_off, lat_size, lat_signed);
                // cnt counts completed WAIT cycles; this is the TIMEOUT_CYCLES-th one.
                end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            cnt              <= '0;
            lat_size         <= '0;
            lat_signed       <= 1'b0;
            lat_off          <= '0;
            req_ready        <= 1'b1;
            resp_valid       <= 1'b0;
            resp_error       <= 1'b0;
            resp_rdata       <= '0;
            mem_valid        <= 1'b0;
            mem_address      <= '0;
            mem_write_data   <= '0;
            mem_byte_enable  <= '0;
            mem_write_enable <= 1'b0;
        end else begin
            state            <= state_d;
            cnt              <= cnt_d;
            lat_size         <= lat_size_d;
            lat_signed       <= lat_signed_d;
            lat_off          <= lat_off_d;
            req_ready        <= req_ready_d;
            resp_valid       <= resp_valid_d;
            resp_error       <= resp_error_d;
            resp_rdata       <= resp_rdata_d;
            mem_valid        <= mem_valid_d;
            mem_address      <= mem_address_d;
            mem_write_data   <= mem_write_data_d;
            mem_byte_enable  <= mem_byte_enable_d;
            mem_write_enable <= mem_write_enable_d;
        end
    end

endmodule

// File: tb/tb_mem_req_initiator.sv
// tb_mem_req_initiator
//   Directed bench for mem_req_initiator with a small behavioural memory.
//   The memory has a 2-cycle internal latency and a one-cycle ready pulse. It
//   can also drop ready to force a timeout.

module tb_mem_req_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [63:0] req_addr, req_wdata;
    logic        resp_valid, resp_error;
    logic [63:0] resp_rdata;
    logic        mem_valid, mem_ready, mem_write_enable, mem_burst_mode;
    logic [63:0] mem_address, mem_write_data, mem_read_data;
    logic [7:0]  mem_byte_enable;
    logic [3:0]  mem_burst_len;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_req_initiator #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_byte_enable(mem_byte_enable),
        .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data),
        .mem_burst_mode(mem_burst_mode), .mem_burst_len(mem_burst_len)
    );

    // Behavioural memory: strobe seen at E1, ready high E4..E5.
    logic [63:0] mem [16];
    logic        mdl_busy, mdl_rdy, drop, inj;
    logic [1:0]  mdl_lat;
    logic        bd_en;
    logic [3:0]  bd_idx;
    logic [63:0] bd_data;

    assign mem_ready = mdl_rdy | inj;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_busy      <= 1'b0;
            mdl_rdy       <= 1'b0;
            mdl_lat       <= 2'd0;
            mem_read_data <= 64'd0;
        end else begin
            mdl_rdy <= 1'b0;
            if (mdl_busy) begin
                if (mdl_lat == 2'd2) begin
                    mdl_busy <= 1'b0;
                    if (!drop) begin
                        mdl_rdy       <= 1'b1;
                        mem_read_data <= mem[mem_address[6:3]];
                    end
                end else begin
                    mdl_lat <= mdl_lat + 2'd1;
                end
            end else if (mem_valid) begin
                mdl_busy <= 1'b1;
                mdl_lat  <= 2'd0;
            end
        end
    end

    always @(posedge clk) begin
        if (bd_en) begin
            mem[bd_idx] <= bd_data;
        end else if (!rst && mdl_busy && mdl_lat == 2'd2 && !drop && mem_write_enable) begin
            for (int i = 0; i < 8; i++)
                if (mem_byte_enable[i])
                    mem[mem_address[6:3]][8*i +: 8] <= mem_write_data[8*i +: 8];
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic backdoor(input logic [3:0] idx, input logic [63:0] data);
        bd_en   = 1'b1;
        bd_idx  = idx;
        bd_data = data;
        @(posedge clk); #1;
        bd_en   = 1'b0;
    endtask

    task automatic run_req(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [63:0] addr, input logic [63:0] wd,
                           input int exp_lat, input int exp_mv, input logic exp_err,
                           input logic [63:0] exp_rdata, input logic [63:0] exp_maddr,
                           input logic [7:0] exp_be, input logic [63:0] exp_wd);
        int          cyc, mv;
        logic        seen, stable, got_err, cap_we;
        logic [63:0] got_rd, cap_addr, cap_wd;
        logic [7:0]  cap_be;
        check({tag, ":req_ready_before"}, req_ready, 1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 0; mv = 0; seen = 1'b0; stable = 1'b1;
        got_err = 1'b0; got_rd = '0; cap_we = 1'b0; cap_addr = '0; cap_wd = '0; cap_be = '0;
        while (!seen && cyc < 40) begin
            if (mem_valid) begin
                mv++;
                cap_addr = mem_address;
                cap_wd   = mem_write_data;
                cap_be   = mem_byte_enable;
                cap_we   = mem_write_enable;
            end else if (mv > 0 && (mem_address !== cap_addr || mem_write_data !== cap_wd ||
                                    mem_byte_enable !== cap_be || mem_write_enable !== cap_we)) begin
                stable = 1'b0;
            end
            if (resp_valid) begin
                seen    = 1'b1;
                got_rd  = resp_rdata;
                got_err = resp_error;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        check({tag, ":resp_seen"}, seen, 1);
        check({tag, ":latency"}, cyc, exp_lat);
        check({tag, ":mem_valid_cycles"}, mv, exp_mv);
        check({tag, ":resp_error"}, got_err, exp_err);
        check({tag, ":resp_rdata"}, got_rd, exp_rdata);
        if (exp_mv > 0) begin
            check({tag, ":mem_address"}, cap_addr, exp_maddr);
            check({tag, ":byte_enable"}, cap_be, exp_be);
            check({tag, ":write_enable"}, cap_we, wr);
            check({tag, ":write_data"}, cap_wd, exp_wd);
            check({tag, ":held_stable"}, stable, 1);
        end
        @(posedge clk); #1;
        check({tag, ":resp_valid_after"}, resp_valid, 0);
        check({tag, ":resp_error_after"}, resp_error, 0);
        check({tag, ":resp_rdata_after"}, resp_rdata, 0);
        check({tag, ":req_ready_after"}, req_ready, 1);
    endtask

    initial begin
        logic flag;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = '0; req_wdata = '0; drop = 1'b0; inj = 1'b0;
        bd_en = 1'b0; bd_idx = '0; bd_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst:req_ready", req_ready, 1);
        check("rst:resp_valid", resp_valid, 0);
        check("rst:mem_valid", mem_valid, 0);
        check("rst:mem_address", mem_address, 0);
        check("rst:byte_enable", mem_byte_enable, 0);
        check("rst:burst", {mem_burst_mode, mem_burst_len}, 0);
        rst = 1'b0;

        backdoor(4'd3, 64'h0123456789ABCDEF);
        backdoor(4'd5, 64'h1122334455667788);
        backdoor(4'd8, 64'h1122334455667788);

        run_req("ld_d40", 0, 2'd3, 0, 64'h40, 0, 5, 1, 0, 64'h1122334455667788, 64'h40, 8'hFF, 0);
        run_req("ldsb_2B", 0, 2'd0, 1, 64'h2B, 0, 5, 1, 0, 64'h55, 64'h28, 8'h08, 0);
        backdoor(4'd5, 64'h80F0334455667788);
        run_req("ldsh_2E", 0, 2'd1, 1, 64'h2E, 0, 5, 1, 0, 64'hFFFFFFFFFFFF80F0, 64'h28, 8'hC0, 0);
        run_req("lduh_2E", 0, 2'd1, 0, 64'h2E, 0, 5, 1, 0, 64'h80F0, 64'h28, 8'hC0, 0);
        run_req("ldsb_2F", 0, 2'd0, 1, 64'h2F, 0, 5, 1, 0, 64'hFFFFFFFFFFFFFF80, 64'h28, 8'h80, 0);
        run_req("ldsw_2C", 0, 2'd2, 1, 64'h2C, 0, 5, 1, 0, 64'hFFFFFFFF80F03344, 64'h28, 8'hF0, 0);
        run_req("stw_1C", 1, 2'd2, 0, 64'h1C, 64'hDEADBEEF, 5, 1, 0, 0, 64'h18, 8'hF0, 64'hDEADBEEF00000000);
        run_req("ld_d18", 0, 2'd3, 0, 64'h18, 0, 5, 1, 0, 64'hDEADBEEF89ABCDEF, 64'h18, 8'hFF, 0);
        run_req("mis_h03", 0, 2'd1, 0, 64'h03, 0, 0, 0, 1, 0, 0, 0, 0);
        run_req("mis_d44", 0, 2'd3, 0, 64'h44, 0, 0, 0, 1, 0, 0, 0, 0);

        drop = 1'b1;
        run_req("tmo_d40", 0, 2'd3, 0, 64'h40, 0, 5, 1, 1, 0, 64'h40, 8'hFF, 0);
        drop = 1'b0;
        inj  = 1'b1;
        @(posedge clk); #1;
        inj  = 1'b0;
        flag = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (resp_valid || !req_ready || mem_valid) flag = 1'b1;
            @(posedge clk); #1;
        end
        check("late_ready_ignored", flag, 0);

        // Reset while the access is in WAIT.
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd3; req_signed = 1'b0; req_addr = 64'h40;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rstw:mem_valid_req", mem_valid, 1);
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        check("rstw:req_ready", req_ready, 1);
        check("rstw:mem_valid", mem_valid, 0);
        check("rstw:mem_address", mem_address, 0);
        check("rstw:byte_enable", mem_byte_enable, 0);
        check("rstw:write_enable", mem_write_enable, 0);
        check("rstw:resp_valid", resp_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_req("post_rst", 0, 2'd3, 0, 64'h40, 0, 5, 1, 0, 64'h1122334455667788, 64'h40, 8'hFF, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
